wb_ram_slave: RTL and testbench
===============================

Name: wb_ram_slave

Overview:
Wishbone classic slave that fronts a single-port synchronous RAM in wb_memory. The RAM has one-cycle registered read (read-before-write) and a single full-width write enable. The block sits directly upstream of that RAM. It converts Wishbone cycles into RAM addr/we/data and generates registered acks. Byte-select writes narrower than a word are done as read-modify-write, because the RAM has no byte enables.

Parameters:
DATA_WIDTH, 32, Wishbone and RAM data width; must be a multiple of 8.
ADDR_WIDTH, 10, word-address width shared by Wishbone and RAM.
SEL_WIDTH, DATA_WIDTH/8, derived; byte-select width; not to be overridden.

Ports:
clk  in  1  single clock; all logic on posedge.
rst_n  in  1  reset, asynchronous, active-low.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  transfer strobe.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  ADDR_WIDTH  word address.
wb_sel_i  in  SEL_WIDTH  byte selects; bit n selects dat[8n+7:8n].
wb_dat_i  in  DATA_WIDTH  write data.
wb_dat_o  out  DATA_WIDTH  read data; registered.
wb_ack_o  out  1  transfer acknowledge; registered, one-cycle pulse.
ram_addr  out  ADDR_WIDTH  RAM address.
ram_we  out  1  RAM write enable.
ram_dat_w  out  DATA_WIDTH  RAM write data.
ram_dat_r  in  DATA_WIDTH  RAM read data; valid one cycle after the address edge.

Behaviour:
- Reset (rst_n low, async): state IDLE; wb_ack_o=0; wb_dat_o=0; latched req regs=0.
- ram_we is forced 0 while rst_n is low, even if cyc/stb are high.
- Request = cyc & stb, sampled only in IDLE. On acceptance, latch adr/dat/sel/we into req regs.
- ram_addr/ram_dat_w source: from wb inputs in IDLE, from req regs in all other states.
- States: IDLE, RD_WAIT, RMW_WAIT, ACK.
- Read (cycle 0 accept, ram_addr=adr, ram_we=0) -> RD_WAIT.
  - RD_WAIT (cycle 1): wb_dat_o<=ram_dat_r, wb_ack_o<=1 -> ACK.
  - wb_ack_o is high in cycle 2, with wb_dat_o valid.
- Full write (sel all ones): in IDLE, ram_we=1 and ram_dat_w=wb_dat_i. wb_ack_o<=1 -> ACK; ack in cycle 1.
- Partial write (sel neither all ones nor 0): in IDLE, ram_we=0 (read old word) -> RMW_WAIT.
  - RMW_WAIT (cycle 1): ram_we=1; ram_dat_w = per byte, sel ? req_dat : ram_dat_r. wb_ack_o<=1 -> ACK.
  - Ack in cycle 2.
- Write with sel=0: no RAM write; wb_ack_o<=1 -> ACK; ack in cycle 1.
- ACK: wb_ack_o<=0 -> IDLE unconditionally. No request is accepted in the ACK cycle, so there is at least one idle cycle between acks.
- Back-to-back: master holding stb with a new address after ack is accepted in the following IDLE cycle.
- Abort: cyc low while in RD_WAIT or RMW_WAIT -> IDLE; no ack, no RAM write, wb_dat_o unchanged.
- stb without cyc: ignored.
- wb_dat_o holds the last read value; writes do not change it.
- Reset asserted mid-operation: immediate return to IDLE, ack 0. A RAM write already clocked stays committed; an RMW write not yet issued never happens.
- Word addressing only; no address error generation; addresses wrap naturally within 2**ADDR_WIDTH.

Decomposition:
- Package wb_ram_pkg holds:
  - state enum typedef (IDLE, RD_WAIT, RMW_WAIT, ACK);
  - localparam for the all-ones select mask derivation;
  - a byte-merge function: (old, new, sel) -> merged.
- One natural sub-module: wb_byte_merge, purely combinational, instantiated for the RMW data path.
- FSM and registers stay in wb_ram_slave.
- Bench instantiates wb_ram_slave with the existing RAM (DATA_WIDTH=32, ADDR_WIDTH=10).

Test Plan:
1. Hold rst_n=0 with cyc=stb=1, we=1 -> ram_we=0, wb_ack_o=0, wb_dat_o=0. Release reset -> first accept on the next edge.
2. Write adr 0x005, dat 0xDEADBEEF, sel 0xF -> ack 1 cycle after accept. Then read adr 0x005 -> ack 2 cycles after accept, wb_dat_o=0xDEADBEEF.
3. Preload 0x11223344 at adr 0x010. Write sel 0x5, dat 0xAABBCCDD -> ack 2 cycles after accept. Read-back = 0x11BB33DD.
4. Write sel 0x0 to adr 0x005 -> ack after 1 cycle, ram_we never high. Read-back still 0xDEADBEEF.
5. Partial write sel 0x2 to adr 0x010, drop cyc in RMW_WAIT -> no ack, no ram_we pulse. Read-back unchanged at 0x11BB33DD.
6. Back-to-back: read 0x005, then a full write 0x3FF=0x12345678 with stb held -> exactly one idle cycle between acks; ram_addr wraps correctly at 0x3FF. Assert rst_n mid-read -> ack never asserts, wb_dat_o=0.

Source files
------------

// File: rtl/wb_ram_pkg.sv
// Shared types and helpers for the Wishbone RAM slave.
// Byte-merge is defined per byte so it is width-independent.
package wb_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RMW_WAIT,
    ACK
  } state_t;

  localparam int BYTE_W = 8;

  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_b,
    input logic [BYTE_W-1:0] new_b,
    input logic              sel_b
  );
    return sel_b ? new_b : old_b;
  endfunction

endpackage

// File: rtl/wb_ram_slave_merge.sv
// Combinational byte merge for the RMW write path.
// Selected bytes come from new data, the rest from the old word.
module wb_byte_merge
  import wb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = DATA_WIDTH/8
) (
  input  logic [DATA_WIDTH-1:0] old_w,
  input  logic [DATA_WIDTH-1:0] new_w,
  input  logic [SEL_WIDTH-1:0]  sel,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar i = 0; i < SEL_WIDTH; i++) begin : g_byte
    assign merged[i*BYTE_W +: BYTE_W] =
      merge_byte(old_w[i*BYTE_W +: BYTE_W],
                 new_w[i*BYTE_W +: BYTE_W],
                 sel[i]);
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone classic slave in front of a single-port sync RAM.
// Partial-select writes are done as read-modify-write.
module wb_ram_slave
  import wb_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int SEL_WIDTH  = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [SEL_WIDTH-1:0]  wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_dat_w,
  input  logic [DATA_WIDTH-1:0] ram_dat_r
);

  localparam logic [SEL_WIDTH-1:0] SEL_ALL = {SEL_WIDTH{1'b1}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] req_adr;
  logic [DATA_WIDTH-1:0] req_dat;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] merged;

  logic req;
  logic sel_full;
  logic sel_none;

  assign req      = wb_cyc_i & wb_stb_i;
  assign sel_full = (wb_sel_i == SEL_ALL);
  assign sel_none = (wb_sel_i == '0);

  wb_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_merge (
    .old_w (ram_dat_r),
    .new_w (req_dat),
    .sel   (req_sel),
    .merged(merged)
  );

  // RAM address: live bus in IDLE, latched request otherwise
  always_comb begin
    ram_addr = req_adr;
    if (state == IDLE) ram_addr = wb_adr_i;
  end

  // RAM write data: bus in IDLE, merged word during RMW
  always_comb begin
    ram_dat_w = req_dat;
    if (state == IDLE)          ram_dat_w = wb_dat_i;
    else if (state == RMW_WAIT) ram_dat_w = merged;
  end

  // Write strobe; reset and abort both suppress it
  always_comb begin
    ram_we = 1'b0;
    if (rst_n) begin
      if (state == IDLE)
        ram_we = req & wb_we_i & sel_full;
      else if (state == RMW_WAIT)
        ram_we = req_we & wb_cyc_i;
    end
  end

  // Transfer FSM with registered ack and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      req_adr  <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      req_we   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wb_ack_o <= 1'b0;
          if (req) begin
            req_adr <= wb_adr_i;
            req_dat <= wb_dat_i;
            req_sel <= wb_sel_i;
            req_we  <= wb_we_i;
            if (!wb_we_i) begin
              state <= RD_WAIT;
            end else if (sel_full || sel_none) begin
              wb_ack_o <= 1'b1;
              state    <= ACK;
            end else begin
              state <= RMW_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else begin
            wb_dat_o <= ram_dat_r;
            wb_ack_o <= 1'b1;
            state    <= ACK;
          end
        end
        RMW_WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else begin
            wb_ack_o <= 1'b1;
            state    <= ACK;
          end
        end
        ACK: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          wb_ack_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave with a behavioural RAM.
// Expected acks (cycle and data) are queued by stimulus.
module tb_wb_ram_slave;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int SW = DW/8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic          wb_we_i;
  logic [AW-1:0] wb_adr_i;
  logic [SW-1:0] wb_sel_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_dat_w;
  logic [DW-1:0] ram_dat_r;

  wb_ram_slave #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_dat_w(ram_dat_w),
    .ram_dat_r(ram_dat_r)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_dat_w;
    ram_dat_r <= mem[ram_addr];
  end

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
    string         nm;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  int            we_pulses = 0;
  logic [AW-1:0] last_we_addr = '0;
  int            ack_prev = -1;
  int            ack_gap = 0;

  always @(negedge clk) begin
    exp_t e;
    if (ram_we) begin
      we_pulses    <= we_pulses + 1;
      last_we_addr <= ram_addr;
    end
    if (wb_ack_o) begin
      if (sb.size() == 0) begin
        chk(1'b0, "spurious_ack", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk(cyc_n == e.cyc, {e.nm, "_lat"}, cyc_n, e.cyc);
        chk(wb_dat_o == e.dat, {e.nm, "_dat"}, wb_dat_o, e.dat);
      end
      if (ack_prev >= 0) ack_gap <= cyc_n - ack_prev;
      ack_prev <= cyc_n;
    end
  end

  logic [DW-1:0] last_rd = '0;

  task automatic xfer(input logic we, input logic [AW-1:0] adr,
                      input logic [DW-1:0] dat,
                      input logic [SW-1:0] sel,
                      input logic [DW-1:0] exp_rd,
                      input int lat, input string nm,
                      input bit hold);
    exp_t e;
    int   n;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    if (!we) last_rd = exp_rd;
    e.cyc = cyc_n + lat;
    e.dat = last_rd;
    e.nm  = nm;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack_o && n < 10);
    if (!wb_ack_o) chk(1'b0, {nm, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got %h want %h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    for (int i = 0; i < 2**AW; i++) mem[i] = '0;

    rst_n    = 1'b0;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 10'h005;
    wb_dat_i = 32'hDEADBEEF;
    wb_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(ram_we == 1'b0, "rst_ram_we", {31'd0, ram_we}, 32'd0);
    chk(wb_ack_o == 1'b0, "rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk(wb_dat_o == '0, "rst_dat", wb_dat_o, 32'd0);
    chk(mem[5] == '0, "rst_no_write", mem[5], 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    xfer(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, '0, 1, "wr_full", 0);
    xfer(1'b0, 10'h005, '0, 4'hF, 32'hDEADBEEF, 2, "rd5", 0);

    xfer(1'b1, 10'h010, 32'h11223344, 4'hF, '0, 1, "preload", 0);
    xfer(1'b1, 10'h010, 32'hAABBCCDD, 4'h5, '0, 2, "rmw5", 0);
    xfer(1'b0, 10'h010, '0, 4'hF, 32'h11BB33DD, 2, "rd_rmw", 0);

    p = we_pulses;
    xfer(1'b1, 10'h005, 32'h0BADF00D, 4'h0, '0, 1, "wr_sel0", 0);
    chk(we_pulses == p, "sel0_no_we", we_pulses, p);
    xfer(1'b0, 10'h005, '0, 4'hF, 32'hDEADBEEF, 2, "rd_sel0", 0);

    p = we_pulses;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 10'h010;
    wb_dat_i = 32'h55667788;
    wb_sel_i = 4'h2;
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk(we_pulses == p, "abort_no_we", we_pulses, p);
    xfer(1'b0, 10'h010, '0, 4'hF, 32'h11BB33DD, 2, "rd_abort", 0);

    xfer(1'b0, 10'h005, '0, 4'hF, 32'hDEADBEEF, 2, "b2b_rd", 1);
    xfer(1'b1, 10'h3FF, 32'h12345678, 4'hF, '0, 1, "b2b_wr", 0);
    chk(ack_gap == 2, "b2b_gap", ack_gap, 32'd2);
    chk(last_we_addr == 10'h3FF, "wrap_addr",
        {22'd0, last_we_addr}, 32'h3FF);
    xfer(1'b0, 10'h3FF, '0, 4'hF, 32'h12345678, 2, "rd_3ff", 0);

    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = 10'h005;
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge clk);
    chk(wb_ack_o == 1'b0, "midrst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk(wb_dat_o == '0, "midrst_dat", wb_dat_o, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    last_rd = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(sb.size() == 0, "sb_empty", sb.size(), 32'd0);
    xfer(1'b0, 10'h3FF, '0, 4'hF, 32'h12345678, 2, "rd_after_rst", 0);

    repeat (3) @(posedge clk);
    #1;
    chk(sb.size() == 0, "sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
